// File: rtl/bf_engine.sv
// Brainfuck execution core with external sync-read program/data RAMs and valid/ready I/O.
// Define BF_DP_BOUNDS_EN to turn data-pointer under/overflow into a halting fault.
module bf_engine #(
   parameter int unsigned PAW = 8,
   parameter int unsigned DAW = 8,
   parameter int unsigned CW  = 8,
   parameter int unsigned NW  = 8
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           go,
   output logic [PAW-1:0] pm_addr,
   input  logic [3:0]     pm_data,
   output logic [DAW-1:0] dm_addr,
   output logic [CW-1:0]  dm_wdata,
   output logic           dm_we,
   input  logic [CW-1:0]  dm_rdata,
   output logic [CW-1:0]  out_data,
   output logic           out_valid,
   input  logic           out_ready,
   input  logic [CW-1:0]  in_data,
   input  logic           in_valid,
   output logic           in_ready,
   output logic           busy,
   output logic           halted,
   output logic           error,
   output logic [PAW-1:0] pc,
   output logic [DAW-1:0] dp,
   output logic [3:0]     state
);

   localparam logic [3:0] OP_HALT  = 4'd0;
   localparam logic [3:0] OP_RIGHT = 4'd1;
   localparam logic [3:0] OP_LEFT  = 4'd2;
   localparam logic [3:0] OP_INC   = 4'd3;
   localparam logic [3:0] OP_DEC   = 4'd4;
   localparam logic [3:0] OP_OUT   = 4'd5;
   localparam logic [3:0] OP_IN    = 4'd6;
   localparam logic [3:0] OP_JZ    = 4'd7;
   localparam logic [3:0] OP_JNZ   = 4'd8;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_EXEC    = 4'd2,
      S_RD      = 4'd3,
      S_WR      = 4'd4,
      S_OUT     = 4'd5,
      S_IN      = 4'd6,
      S_BR      = 4'd7,
      S_SCANF_A = 4'd8,
      S_SCANF_E = 4'd9,
      S_SCANB_A = 4'd10,
      S_SCANB_E = 4'd11,
      S_HALT    = 4'd12
   } state_t;

   state_t         r_state, w_state_nxt;
   logic [PAW-1:0] r_pc, w_pc_nxt;
   logic [DAW-1:0] r_dp, w_dp_nxt;
   logic [NW-1:0]  r_depth, w_depth_nxt;
   logic [3:0]     r_op, w_op_nxt;
   logic           r_error, w_error_nxt;
   logic           r_we, w_we_nxt;
   logic [CW-1:0]  r_wdata, w_wdata_nxt;
   logic [CW-1:0]  r_out_data, w_out_data_nxt;
   logic           r_out_valid, w_out_valid_nxt;
   logic           r_in_ready, w_in_ready_nxt;
   logic           r_busy, r_halted;
   logic           w_lo_fault, w_hi_fault;

`ifdef BF_DP_BOUNDS_EN
   assign w_lo_fault = (r_dp == '0);
   assign w_hi_fault = &r_dp;
`else
   assign w_lo_fault = 1'b0;
   assign w_hi_fault = 1'b0;
`endif

   // Next-state and next-output decode
   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_dp_nxt        = r_dp;
      w_depth_nxt     = r_depth;
      w_op_nxt        = r_op;
      w_error_nxt     = r_error;
      w_we_nxt        = 1'b0;
      w_wdata_nxt     = r_wdata;
      w_out_data_nxt  = r_out_data;
      w_out_valid_nxt = r_out_valid;
      w_in_ready_nxt  = r_in_ready;
      case (r_state)
         S_IDLE, S_HALT: begin
            if (go) begin
               w_pc_nxt    = '0;
               w_dp_nxt    = '0;
               w_depth_nxt = '0;
               w_error_nxt = 1'b0;
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: w_state_nxt = S_EXEC;
         S_EXEC: begin
            w_op_nxt = pm_data;
            case (pm_data)
               OP_HALT: w_state_nxt = S_HALT;
               OP_RIGHT: begin
                  if (w_hi_fault) begin
                     w_error_nxt = 1'b1;
                     w_state_nxt = S_HALT;
                  end else begin
                     w_dp_nxt    = r_dp + DAW'(1);
                     w_pc_nxt    = r_pc + PAW'(1);
                     w_state_nxt = S_FETCH;
                  end
               end
               OP_LEFT: begin
                  if (w_lo_fault) begin
                     w_error_nxt = 1'b1;
                     w_state_nxt = S_HALT;
                  end else begin
                     w_dp_nxt    = r_dp - DAW'(1);
                     w_pc_nxt    = r_pc + PAW'(1);
                     w_state_nxt = S_FETCH;
                  end
               end
               OP_INC, OP_DEC, OP_OUT, OP_JZ, OP_JNZ: w_state_nxt = S_RD;
               OP_IN: begin
                  w_in_ready_nxt = 1'b1;
                  w_state_nxt    = S_IN;
               end
               default: begin
                  w_pc_nxt    = r_pc + PAW'(1);
                  w_state_nxt = S_FETCH;
               end
            endcase
         end
         S_RD: begin
            if (r_op == OP_INC || r_op == OP_DEC) w_state_nxt = S_WR;
            else if (r_op == OP_OUT)              w_state_nxt = S_OUT;
            else                                  w_state_nxt = S_BR;
         end
         // Write data is registered, so the RAM write lands in the following FETCH
         S_WR: begin
            w_we_nxt    = 1'b1;
            w_wdata_nxt = (r_op == OP_INC) ? dm_rdata + CW'(1) : dm_rdata - CW'(1);
            w_pc_nxt    = r_pc + PAW'(1);
            w_state_nxt = S_FETCH;
         end
         S_OUT: begin
            if (!r_out_valid) begin
               w_out_data_nxt  = dm_rdata;
               w_out_valid_nxt = 1'b1;
            end else if (out_ready) begin
               w_out_valid_nxt = 1'b0;
               w_pc_nxt        = r_pc + PAW'(1);
               w_state_nxt     = S_FETCH;
            end
         end
         S_IN: begin
            if (in_valid && r_in_ready) begin
               w_we_nxt       = 1'b1;
               w_wdata_nxt    = in_data;
               w_in_ready_nxt = 1'b0;
               w_pc_nxt       = r_pc + PAW'(1);
               w_state_nxt    = S_FETCH;
            end
         end
         // A scan that would start beyond either end of program memory cannot match
         S_BR: begin
            if (r_op == OP_JZ) begin
               if (dm_rdata != '0) begin
                  w_pc_nxt    = r_pc + PAW'(1);
                  w_state_nxt = S_FETCH;
               end else if (&r_pc) begin
                  w_error_nxt = 1'b1;
                  w_state_nxt = S_HALT;
               end else begin
                  w_depth_nxt = NW'(1);
                  w_pc_nxt    = r_pc + PAW'(1);
                  w_state_nxt = S_SCANF_A;
               end
            end else begin
               if (dm_rdata == '0) begin
                  w_pc_nxt    = r_pc + PAW'(1);
                  w_state_nxt = S_FETCH;
               end else if (r_pc == '0) begin
                  w_error_nxt = 1'b1;
                  w_state_nxt = S_HALT;
               end else begin
                  w_depth_nxt = NW'(1);
                  w_pc_nxt    = r_pc - PAW'(1);
                  w_state_nxt = S_SCANB_A;
               end
            end
         end
         S_SCANF_A: w_state_nxt = S_SCANF_E;
         S_SCANF_E: begin
            if (pm_data == OP_JZ && (&r_depth)) begin
               w_error_nxt = 1'b1;
               w_state_nxt = S_HALT;
            end else if (pm_data == OP_JNZ && r_depth == NW'(1)) begin
               w_depth_nxt = '0;
               w_pc_nxt    = r_pc + PAW'(1);
               w_state_nxt = S_FETCH;
            end else if (&r_pc) begin
               w_error_nxt = 1'b1;
               w_state_nxt = S_HALT;
            end else begin
               if (pm_data == OP_JZ)       w_depth_nxt = r_depth + NW'(1);
               else if (pm_data == OP_JNZ) w_depth_nxt = r_depth - NW'(1);
               w_pc_nxt    = r_pc + PAW'(1);
               w_state_nxt = S_SCANF_A;
            end
         end
         S_SCANB_A: w_state_nxt = S_SCANB_E;
         S_SCANB_E: begin
            if (pm_data == OP_JNZ && (&r_depth)) begin
               w_error_nxt = 1'b1;
               w_state_nxt = S_HALT;
            end else if (pm_data == OP_JZ && r_depth == NW'(1)) begin
               w_depth_nxt = '0;
               w_pc_nxt    = r_pc + PAW'(1);
               w_state_nxt = S_FETCH;
            end else if (r_pc == '0) begin
               w_error_nxt = 1'b1;
               w_state_nxt = S_HALT;
            end else begin
               if (pm_data == OP_JNZ)     w_depth_nxt = r_depth + NW'(1);
               else if (pm_data == OP_JZ) w_depth_nxt = r_depth - NW'(1);
               w_pc_nxt    = r_pc - PAW'(1);
               w_state_nxt = S_SCANB_A;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_pc        <= '0;
         r_dp        <= '0;
         r_depth     <= '0;
         r_op        <= '0;
         r_error     <= 1'b0;
         r_we        <= 1'b0;
         r_wdata     <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b0;
         r_busy      <= 1'b0;
         r_halted    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_dp        <= w_dp_nxt;
         r_depth     <= w_depth_nxt;
         r_op        <= w_op_nxt;
         r_error     <= w_error_nxt;
         r_we        <= w_we_nxt;
         r_wdata     <= w_wdata_nxt;
         r_out_data  <= w_out_data_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_busy      <= !(w_state_nxt == S_IDLE || w_state_nxt == S_HALT);
         r_halted    <= (w_state_nxt == S_HALT);
      end
   end

   assign pm_addr   = r_pc;
   assign pc        = r_pc;
   assign dm_addr   = r_dp;
   assign dp        = r_dp;
   assign dm_we     = r_we;
   assign dm_wdata  = r_wdata;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign in_ready  = r_in_ready;
   assign busy      = r_busy;
   assign halted    = r_halted;
   assign error     = r_error;
   assign state     = r_state;

endmodule

// File: tb/tb_bf_engine.sv
// Directed self-checking bench for bf_engine with behavioural program ROM and data RAM.
module tb_bf_engine;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       go = 1'b0;
   logic [7:0] pm_addr;
   logic [3:0] pm_data;
   logic [7:0] dm_addr, dm_wdata, dm_rdata;
   logic       dm_we;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready, busy, halted, error;
   logic [7:0] pc, dp;
   logic [3:0] state;

   always #5 clock = ~clock;

   bf_engine dut (
      .clock(clock), .reset(reset), .go(go),
      .pm_addr(pm_addr), .pm_data(pm_data),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .busy(busy), .halted(halted), .error(error),
      .pc(pc), .dp(dp), .state(state)
   );

   logic [3:0] prog [256];
   logic [7:0] mem [256];
   logic       tb_clr = 1'b0;

   always @(posedge clock) pm_data <= prog[pm_addr];

   always @(posedge clock) begin
      if (tb_clr) for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      else if (dm_we) mem[dm_addr] <= dm_wdata;
      dm_rdata <= mem[dm_addr];
   end

   // Activity monitors sampled on the active edge
   int         cyc = 0, beats = 0, we_n = 0, fetch_n = 0;
   logic [7:0] last_out = 8'h00;
   int         fetch_cyc [1024];
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (out_valid && out_ready) begin
         beats    <= beats + 1;
         last_out <= out_data;
      end
      if (dm_we) we_n <= we_n + 1;
      if (state == 4'd1) begin
         fetch_cyc[fetch_n % 1024] <= cyc;
         fetch_n <= fetch_n + 1;
      end
   end

   int n_checks = 0, n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] enc(input byte c);
      case (c)
         ">": return 4'd1;
         "<": return 4'd2;
         "+": return 4'd3;
         "-": return 4'd4;
         ".": return 4'd5;
         ",": return 4'd6;
         "[": return 4'd7;
         "]": return 4'd8;
         default: return 4'd0;
      endcase
   endfunction

   task automatic load(input string s);
      for (int i = 0; i < 256; i++) prog[i] = 4'd0;
      for (int i = 0; i < s.len(); i++) prog[i] = enc(s[i]);
      tb_clr = 1'b1;
      @(negedge clock);
      tb_clr = 1'b0;
   endtask

   task automatic pulse_go();
      @(negedge clock);
      go = 1'b1;
      @(negedge clock);
      go = 1'b0;
   endtask

   task automatic wait_halt(input string tag, input int budget);
      int n = 0;
      while (!halted && n < budget) begin
         @(negedge clock);
         n++;
      end
      check(tag, 32'(halted), 32'd1);
   endtask

   task automatic run(input string tag, input int budget);
      pulse_go();
      wait_halt(tag, budget);
   endtask

   int b0, w0, f0, n;

   initial begin
      for (int i = 0; i < 256; i++) prog[i] = 4'd0;
      repeat (3) @(negedge clock);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_dm_we", 32'(dm_we), 32'd0);
      check("rst_flags", {29'd0, error, halted, busy}, 32'd0);
      check("rst_pc_dp", {16'd0, pc, dp}, 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      reset = 1'b1;
      @(negedge clock);

      // "+++." : three increments then one output beat of 3
      load("+++.");
      b0 = beats; f0 = fetch_n;
      run("t1_halt", 200);
      check("t1_beats", 32'(beats - b0), 32'd1);
      check("t1_out", 32'(last_out), 32'd3);
      check("t1_cell0", 32'(mem[0]), 32'd3);
      check("t1_inc_cycles", 32'(fetch_cyc[(f0 + 1) % 1024] - fetch_cyc[f0 % 1024]), 32'd4);
      check("t1_pc", 32'(pc), 32'd4);
      check("t1_busy", 32'(busy), 32'd0);

      // "[+]." with cell0=0 skips the loop body
      load("[+].");
      b0 = beats;
      run("t2_halt", 200);
      check("t2_out", 32'(last_out), 32'd0);
      check("t2_beats", 32'(beats - b0), 32'd1);
      check("t2_pc", 32'(pc), 32'd4);
      check("t2_err", 32'(error), 32'd0);
      check("t2_cell0", 32'(mem[0]), 32'd0);

      // Move loop: cell0 2 -> 0, cell1 0 -> 2
      load("++[->+<]>.");
      run("t3_halt", 1000);
      check("t3_out", 32'(last_out), 32'd2);
      check("t3_cell0", 32'(mem[0]), 32'd0);
      check("t3_cell1", 32'(mem[1]), 32'd2);
      check("t3_pc", 32'(pc), 32'd10);
      check("t3_dp", 32'(dp), 32'd1);

      // Cell wrap: 0 - 1 = 0xFF
      load("-.");
      run("t4_halt", 200);
      check("t4_out", 32'(last_out), 32'hFF);

      // Input with a stalled producer
      load(",");
      w0 = we_n;
      in_valid = 1'b0;
      pulse_go();
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         check($sformatf("t5_in_ready_%0d", i), 32'(in_ready), 32'd1);
         @(negedge clock);
      end
      check("t5_no_write", 32'(we_n - w0), 32'd0);
      in_data  = 8'h5A;
      in_valid = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      check("t5_in_ready_drop", 32'(in_ready), 32'd0);
      wait_halt("t5_halt", 200);
      check("t5_we_count", 32'(we_n - w0), 32'd1);
      check("t5_cell0", 32'(mem[0]), 32'h5A);

      // Unmatched '[' runs off the end of program memory
      load("[[]");
      run("t6_halt", 2000);
      check("t6_err", 32'(error), 32'd1);
      check("t6_busy", 32'(busy), 32'd0);
      pulse_go();
      check("t6_err_clear", 32'(error), 32'd0);
      check("t6_pc_restart", 32'(pc), 32'd0);
      check("t6_busy_restart", 32'(busy), 32'd1);
      wait_halt("t6_halt2", 2000);
      check("t6_err2", 32'(error), 32'd1);

      // '<' at dp=0
      load("<+.");
      b0 = beats;
      run("t7_halt", 200);
`ifdef BF_DP_BOUNDS_EN
      check("t7_err", 32'(error), 32'd1);
      check("t7_dp", 32'(dp), 32'd0);
      check("t7_pc", 32'(pc), 32'd0);
      check("t7_beats", 32'(beats - b0), 32'd0);
`else
      check("t7_err", 32'(error), 32'd0);
      check("t7_dp", 32'(dp), 32'd255);
      check("t7_pc", 32'(pc), 32'd3);
      check("t7_out", 32'(last_out), 32'd1);
      check("t7_cell255", 32'(mem[255]), 32'd1);
`endif

      // Output stall then asynchronous reset
      load("+.");
      out_ready = 1'b0;
      pulse_go();
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clock);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t8_valid_%0d", i), 32'(out_valid), 32'd1);
         check($sformatf("t8_data_%0d", i), 32'(out_data), 32'd1);
         @(negedge clock);
      end
      #2 reset = 1'b0;
      #1;
      check("t8_valid_async", 32'(out_valid), 32'd0);
      check("t8_busy_async", 32'(busy), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      out_ready = 1'b1;
      @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bf_engine.md
Name: bf_engine

Overview:
- Parametrised second-generation Brainfuck execution core.
- Widths of program address, data address and cell are generic; program/data memories are external synchronous-read RAMs.
- Output and input use valid/ready handshakes instead of switch/level strobes.
- Adds hardware bracket matching with a nesting counter, halt/error status and run/restart control; sits between the program ROM, the data RAM and the board I/O glue.

Parameters:
PAW, 8, program-memory address width (program length up to 2^PAW).
DAW, 8, data-pointer / data-memory address width.
CW, 8, cell width; arithmetic is modulo 2^CW.
NW, 8, bracket nesting counter width.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
go  in  1  start pulse; sampled in IDLE/HALT only
pm_addr  out  PAW  program address (= pc)
pm_data  in  4  opcode; valid one cycle after pm_addr changes
dm_addr  out  DAW  data address (= dp)
dm_wdata  out  CW  write data
dm_we  out  1  write enable, one cycle per write
dm_rdata  in  CW  read data; valid one cycle after dm_addr is presented
out_data  out  CW  output byte
out_valid  out  1  output valid
out_ready  in  1  sink accepts
in_data  in  CW  input byte
in_valid  in  1  input available
in_ready  out  1  engine accepts input
busy  out  1  high in every state except IDLE/HALT
halted  out  1  high in HALT
error  out  1  sticky fault flag; cleared by go or reset
pc  out  PAW  program counter
dp  out  DAW  data pointer
state  out  4  state encoding, for debug

Behaviour:
- Opcodes: 0 HALT, 1 '>', 2 '<', 3 '+', 4 '-', 5 '.', 6 ',', 7 '[', 8 ']'; 9-15 are NOP (pc+1).
- Reset (async, active-low): state=IDLE, pc=0, dp=0, depth=0; out_valid=0, in_ready=0, dm_we=0, error=0, halted=0, busy=0, out_data=0.
- IDLE/HALT: go=1 -> pc=0, dp=0, error=0 -> FETCH. Data RAM is not cleared.
- FETCH: pm_addr=pc, wait one cycle -> EXEC.
- EXEC decodes pm_data:
  - '>'/'<': dp±1 (mod 2^DAW), pc+1 -> FETCH. Total 2 cycles.
  - '+', '-', '.', '[', ']' -> RD.
  - ',' -> IN.
  - HALT -> HALT; pc is held.
- RD: present dp, wait one cycle; the next state sees dm_rdata.
  - '+'/'-' -> WR: dm_we=1 for one cycle, dm_wdata=rdata±1 mod 2^CW, pc+1 -> FETCH. Total 4 cycles.
  - '.' -> OUT: out_data=rdata, out_valid=1. Hold until out_valid&&out_ready, then out_valid=0, pc+1 -> FETCH.
  - '[': rdata!=0 -> pc+1 -> FETCH. rdata==0 -> depth=1, pc+1 -> SCANF.
  - ']': rdata==0 -> pc+1 -> FETCH. rdata!=0 -> depth=1, pc-1 -> SCANB.
- IN: in_ready=1. On in_valid&&in_ready: one-cycle write of in_data to dp, in_ready=0, pc+1 -> FETCH.
- SCANF (2 cycles per opcode: address, then evaluate):
  - '[' increments depth; ']' decrements depth.
  - ']' taking depth to 0 -> pc=that address+1 -> FETCH; otherwise pc+1 and continue.
- SCANB: mirror of SCANF.
  - ']' increments depth; '[' decrements depth.
  - '[' taking depth to 0 -> pc=that address+1 -> FETCH; otherwise pc-1 and continue.
- Scan faults: error=1 -> HALT in any of these cases:
  - depth would exceed 2^NW-1;
  - SCANF evaluates address 2^PAW-1 without a match;
  - SCANB evaluates address 0 without a match.
- pc wrap in normal execution: pc+1 from 2^PAW-1 wraps to 0 without error.
- go while busy is ignored. Handshake stalls are unbounded; no timeout.
- Reset asserted mid-instruction: a pending dm_we, out_valid or in_ready is dropped immediately (async).

Optional Feature:
BF_DP_BOUNDS_EN.
- Defined: '<' at dp=0, or '>' at dp=2^DAW-1, sets error=1 and enters HALT. dp and pc are unchanged.
- Undefined: dp wraps modulo 2^DAW silently.

Test Plan:
- Program "+++." (3,3,3,5,0), out_ready=1, go pulse -> out_data=3 with exactly one out_valid beat, then halted=1. dm location 0 ends at 3, and "+" takes 4 cycles FETCH->FETCH.
- Program "[+]." with cell0=0 -> scan skips the loop. out_data=0; pc at halt equals the address of the HALT opcode; error=0.
- Program "++[->+<]>." -> out_data=2; cell0=0, cell1=2.
- Program "," with in_valid held low for 10 cycles, then in_data=0x5A -> in_ready stays high throughout; one dm_we writes 0x5A to dp=0.
- Program "[[]" (cell=0, scan runs off the end) -> error=1, halted=1. Next go -> error=0, pc=0.
- '<' at dp=0 -> with BF_DP_BOUNDS_EN: error=1 and HALT; without: dp=2^DAW-1 (255) and execution continues. Additionally, '.' with out_ready=0 for 5 cycles keeps out_valid and out_data stable; asserting reset during the stall clears out_valid asynchronously.
